// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: initiator side of the data-memory port.
// It turns byte, half and word loads and stores from the CPU into whole-word dm_12k accesses.
// Sub-word stores use read-modify-write. Loads are extracted and then sign- or zero-extended.
// Optional feature macro: DM_MISALIGN_TRAP_EN. When it is defined, misaligned halves and words
// are rejected with err. When it is undefined, the low address bits are ignored.
module dm_access_ctrl #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned MEM_BYTES = 12288
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    input  logic [31:0]       dm_dout
);

    localparam logic [31:0] LastWord = 32'(MEM_BYTES - 4);

    typedef enum logic [2:0] {StIdle, StRd, StWr, StDone, StErr} state_e;

    state_e            state_q, state_d;
    logic              wr_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;

    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       req_aligned;
    logic              misalign;
    logic              illegal;
    logic [31:0]       load_val;
    logic [31:0]       merged;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    assign word_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign req_aligned = 32'({addr[ADDR_W-1:2], 2'b00});

`ifdef DM_MISALIGN_TRAP_EN
    assign misalign = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign illegal = (size == 2'b11) || (req_aligned > LastWord) || misalign;

    // Load extraction from the combinational DM read data, little-endian lanes
    always_comb begin
        ld_byte  = 8'h00;
        ld_half  = 16'h0000;
        load_val = dm_dout;
        unique case (addr_q[1:0])
            2'b00: ld_byte = dm_dout[7:0];
            2'b01: ld_byte = dm_dout[15:8];
            2'b10: ld_byte = dm_dout[23:16];
            2'b11: ld_byte = dm_dout[31:24];
        endcase
        ld_half = addr_q[1] ? dm_dout[31:16] : dm_dout[15:0];
        if (size_q == 2'b00) begin
            load_val = {{24{sext_q & ld_byte[7]}}, ld_byte};
        end else if (size_q == 2'b01) begin
            load_val = {{16{sext_q & ld_half[15]}}, ld_half};
        end
    end

    // Store merge: the new lane is placed into the previously captured word
    always_comb begin
        merged = word_q;
        if (size_q == 2'b10) begin
            merged = wdata_q;
        end else if (size_q == 2'b01) begin
            if (addr_q[1]) merged[31:16] = wdata_q[15:0];
            else           merged[15:0]  = wdata_q[15:0];
        end else begin
            unique case (addr_q[1:0])
                2'b00: merged[7:0]   = wdata_q[7:0];
                2'b01: merged[15:8]  = wdata_q[7:0];
                2'b10: merged[23:16] = wdata_q[7:0];
                2'b11: merged[31:24] = wdata_q[7:0];
            endcase
        end
    end

    // Next-state logic and the handshake and DM port outputs
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        dm_addr = '0;
        dm_din  = '0;
        dm_we   = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (req) begin
                    if (illegal)                    state_d = StErr;
                    else if (!wr || size != 2'b10)  state_d = StRd;
                    else                            state_d = StWr;
                end
            end
            StRd: begin
                dm_addr = word_addr;
                state_d = wr_q ? StWr : StDone;
            end
            StWr: begin
                dm_addr = word_addr;
                dm_din  = merged;
                // Gate the write so that a reset edge can never commit a half-finished store
                dm_we   = ~rst;
                state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            StErr: begin
                done    = 1'b1;
                err     = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register, request latch, read-word capture and load result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req) begin
                wr_q    <= wr;
                size_q  <= size;
                sext_q  <= sext;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state_q == StRd) begin
                word_q <= dm_dout;
                if (!wr_q) rdata <= load_val;
            end
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: a behavioural dm_12k, a byte-array reference model and an expectation
// queue that is filled when a request is issued and drained when done rises.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr, sext;
    logic [1:0]  size;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic        ready, done, err, dm_we;
    logic [31:0] rdata, dm_din, dm_dout;
    logic [13:0] dm_addr;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          wes;
    } exp_t;
    exp_t sb[$];

    logic [31:0] dm_mem [0:4095];
    logic [7:0]  ref_b  [0:12287];
    logic [31:0] rdata_m;

    always #5 clk = ~clk;

    dm_access_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .sext    (sext),
        .addr    (addr),
        .wdata   (wdata),
        .ready   (ready),
        .done    (done),
        .err     (err),
        .rdata   (rdata),
        .dm_addr (dm_addr),
        .dm_din  (dm_din),
        .dm_we   (dm_we),
        .dm_dout (dm_dout)
    );

    // Behavioural dm_12k: combinational read, write on the clock edge
    assign dm_dout = dm_mem[dm_addr[13:2]];
    always @(posedge clk) if (dm_we) dm_mem[dm_addr[13:2]] <= dm_din;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Issue one access from a negedge; noise=1 holds a conflicting store request while busy
    task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                          input logic [13:0] a, input logic [31:0] wd, input bit noise);
        exp_t e, got;
        int   base, lat, wes, nb;
        bit   seen;
        logic [31:0] v;
        e.err = (sz == 2'b11) || ((int'(a) & ~3) > 12284);
`ifdef DM_MISALIGN_TRAP_EN
        if ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) e.err = 1'b1;
`endif
        nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        base = int'(a) & ~(nb - 1);
        if (!e.err) begin
            if (w) begin
                for (int i = 0; i < nb; i++) ref_b[base + i] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_b[base + i];
                if (sx && v[8*nb-1]) for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
                rdata_m = v;
            end
        end
        e.rdata = rdata_m;
        e.lat   = e.err ? 1 : (w && sz != 2'b10) ? 3 : 2;
        e.wes   = (w && !e.err) ? 1 : 0;
        sb.push_back(e);

        check({tag, " ready"}, {31'b0, ready}, 32'd1);
        req = 1'b1; wr = w; size = sz; sext = sx; addr = a; wdata = wd;
        @(posedge clk);
        #1;
        if (noise) begin
            wr = 1'b1; size = 2'b10; addr = 14'h010; wdata = 32'h0BADF00D;
        end else begin
            req = 1'b0;
        end
        lat = 0; wes = 0; seen = 0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            lat++;
            if (dm_we) wes++;
            if (done) seen = 1;
        end
        req = 1'b0;
        got = sb.pop_front();
        check({tag, " latency"}, lat, got.lat);
        check({tag, " err"}, {31'b0, err}, {31'b0, got.err});
        check({tag, " rdata"}, rdata, got.rdata);
        check({tag, " dm_we pulses"}, wes, got.wes);
        @(negedge clk);
        check({tag, " done one cycle"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) dm_mem[i] = '0;
        for (int i = 0; i < 12288; i++) ref_b[i] = '0;
        rdata_m = '0;
        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; sext = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst ready", {31'b0, ready}, 32'd1);
        check("rst done", {31'b0, done}, 32'd0);
        check("rst err", {31'b0, err}, 32'd0);
        check("rst rdata", rdata, 32'd0);
        check("rst dm_addr", {18'b0, dm_addr}, 32'd0);
        check("rst dm_din", dm_din, 32'd0);
        check("rst dm_we", {31'b0, dm_we}, 32'd0);

        access("sw 0x010", 1'b1, 2'b10, 1'b0, 14'h010, 32'hDEADBEEF, 1'b0);
        check("dm word 0x010 after sw", dm_mem[4], 32'hDEADBEEF);
        access("lw 0x010", 1'b0, 2'b10, 1'b0, 14'h010, 32'h0, 1'b0);
        access("sb 0x011", 1'b1, 2'b00, 1'b0, 14'h011, 32'h000000AA, 1'b0);
        access("lw 0x010 after sb", 1'b0, 2'b10, 1'b0, 14'h010, 32'h0, 1'b0);
        check("model word 0x010", rdata_m, 32'hDEADAAEF);
        access("lb 0x013", 1'b0, 2'b00, 1'b1, 14'h013, 32'h0, 1'b0);
        check("lb value", rdata_m, 32'hFFFFFFDE);
        access("lbu 0x013", 1'b0, 2'b00, 1'b0, 14'h013, 32'h0, 1'b0);
        access("lh 0x012", 1'b0, 2'b01, 1'b1, 14'h012, 32'h0, 1'b0);
        check("lh value", rdata_m, 32'hFFFFDEAD);
        access("lhu 0x010", 1'b0, 2'b01, 1'b0, 14'h010, 32'h0, 1'b0);
        access("lw 0x011", 1'b0, 2'b10, 1'b0, 14'h011, 32'h0, 1'b0);
        access("lw 0x3000", 1'b0, 2'b10, 1'b0, 14'h3000, 32'h0, 1'b0);
        access("size 11", 1'b0, 2'b11, 1'b0, 14'h010, 32'h0, 1'b0);
        access("sw 0x3000", 1'b1, 2'b10, 1'b0, 14'h3000, 32'h12345678, 1'b0);
        access("sw 0x2FFC", 1'b1, 2'b10, 1'b0, 14'h2FFC, 32'h80017FFE, 1'b0);
        access("sh 0x2FFE", 1'b1, 2'b01, 1'b0, 14'h2FFE, 32'hFFFF8642, 1'b0);
        access("lw 0x2FFC", 1'b0, 2'b10, 1'b0, 14'h2FFC, 32'h0, 1'b0);
        access("lb 0x2FFD", 1'b0, 2'b00, 1'b1, 14'h2FFD, 32'h0, 1'b0);
        access("lw 0x010 busy req", 1'b0, 2'b10, 1'b0, 14'h010, 32'h0, 1'b1);
        check("dm word 0x010 after busy req", dm_mem[4], 32'hDEADAAEF);

        // Store interrupted by reset while in WR: no write, no done
        req = 1'b1; wr = 1'b1; size = 2'b01; sext = 1'b0; addr = 14'h010; wdata = 32'h00001234;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check("sh reset: in RD no we", {31'b0, dm_we}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("sh reset: we gated", {31'b0, dm_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("sh reset: no done", {31'b0, done}, 32'd0);
        check("sh reset: ready", {31'b0, ready}, 32'd1);
        check("sh reset: dm word kept", dm_mem[4], 32'hDEADAAEF);
        rdata_m = '0;
        access("lw 0x010 after reset", 1'b0, 2'b10, 1'b0, 14'h010, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
